// File: rtl/adder_arbiter_pkg.sv
// Shared types for the adder arbiter: requester id width, id type,
// and the id-to-one-hot helper used for gnt and rsp_valid.
package adder_arb_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int NREQ_DEF  = 4;
  localparam int REQ_ID_W  = $clog2(NREQ_DEF);

  typedef logic [REQ_ID_W-1:0] req_id_t;

  function automatic logic [NREQ_DEF-1:0] onehot(input req_id_t id);
    logic [NREQ_DEF-1:0] r;
    r     = '0;
    r[id] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/adder_arbiter_if.sv
// Request/response bundle between game controllers (master) and the
// arbiter (slave): en, req, sub, a, b in; gnt, rsp_valid, rsp_sum/cf/of out.
interface adder_arbiter_if
  import adder_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREQ  = NREQ_DEF
);

  logic                  en;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       sub;
  logic [NREQ*WIDTH-1:0] a;
  logic [NREQ*WIDTH-1:0] b;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_cf;
  logic                  rsp_of;

  modport master (
    output en, req, sub, a, b,
    input  gnt, rsp_valid, rsp_sum, rsp_cf, rsp_of
  );

  modport slave (
    input  en, req, sub, a, b,
    output gnt, rsp_valid, rsp_sum, rsp_cf, rsp_of
  );

endinterface

// File: rtl/adder_arbiter_addn.sv
// addN: combinational N-bit add/subtract with carry and overflow flags.
// Ports: i_a, i_b, i_sub in; o_s, o_cf, o_of out.
module addN #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_sub,
  output logic [N-1:0] o_s,
  output logic         o_cf,
  output logic         o_of
);

  logic [N-1:0] w_bx;
  logic [N:0]   w_full;

  assign w_bx   = i_b ^ {N{i_sub}};
  assign w_full = {1'b0, i_a} + {1'b0, w_bx} + {{N{1'b0}}, i_sub};
  assign o_s    = w_full[N-1:0];
  assign o_cf   = w_full[N];
  // Overflow judged against the possibly-inverted B operand.
  assign o_of   = (i_a[N-1] == w_bx[N-1]) && (o_s[N-1] != i_a[N-1]);

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one addN over a 2-stage pipeline.
// Ports: clk, reset (async, active-high), bus (adder_arbiter_if.slave).
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREQ  = NREQ_DEF
) (
  input  logic            clk,
  input  logic            reset,
  adder_arbiter_if.slave  bus
);

  req_id_t          r_ptr;
  req_id_t          r_s1_id;
  logic             r_s1_vld;
  logic             r_s1_sub;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [NREQ-1:0]  r_gnt;
  logic [NREQ-1:0]  r_rsp_vld;
  logic [WIDTH-1:0] r_sum;
  logic             r_cf;
  logic             r_of;

  req_id_t          w_win;
  req_id_t          w_idx;
  req_id_t          w_nxt_ptr;
  logic             w_found;
  logic [WIDTH-1:0] w_sum;
  logic             w_cf;
  logic             w_of;

  // Rotating scan: first set req at or above the pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = req_id_t'((int'(r_ptr) + k) % NREQ);
      if (!w_found && bus.req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_nxt_ptr = (w_win == req_id_t'(NREQ - 1))
                   ? '0
                   : req_id_t'(w_win + 1'b1);

  addN #(.N(WIDTH)) u_add (
    .i_a   (r_s1_a),
    .i_b   (r_s1_b),
    .i_sub (r_s1_sub),
    .o_s   (w_sum),
    .o_cf  (w_cf),
    .o_of  (w_of)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr     <= '0;
      r_s1_id   <= '0;
      r_s1_vld  <= 1'b0;
      r_s1_sub  <= 1'b0;
      r_s1_a    <= '0;
      r_s1_b    <= '0;
      r_gnt     <= '0;
      r_rsp_vld <= '0;
      r_sum     <= '0;
      r_cf      <= 1'b0;
      r_of      <= 1'b0;
    end else begin
      // Pulses drop on every edge; a stalled edge never repeats one.
      r_gnt     <= '0;
      r_rsp_vld <= '0;
      if (bus.en) begin
        if (w_found) begin
          r_s1_vld <= 1'b1;
          r_s1_id  <= w_win;
          r_s1_sub <= bus.sub[w_win];
          r_s1_a   <= bus.a[int'(w_win)*WIDTH +: WIDTH];
          r_s1_b   <= bus.b[int'(w_win)*WIDTH +: WIDTH];
          r_gnt    <= NREQ'(onehot(w_win));
          r_ptr    <= w_nxt_ptr;
        end else begin
          r_s1_vld <= 1'b0;
        end
        if (r_s1_vld) begin
          r_rsp_vld <= NREQ'(onehot(r_s1_id));
          r_sum     <= w_sum;
          r_cf      <= w_cf;
          r_of      <= w_of;
        end
      end
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.rsp_valid = r_rsp_vld;
  assign bus.rsp_sum   = r_sum;
  assign bus.rsp_cf    = r_cf;
  assign bus.rsp_of    = r_of;

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter (WIDTH=4, NREQ=4).
// Expected responses are queued at grant time and popped on rsp_valid.
module tb_adder_arbiter;
  import adder_arb_pkg::*;

  localparam int W  = 4;
  localparam int NR = 4;

  typedef struct {
    int         id;
    logic [W-1:0] sum;
    logic       cf;
    logic       of;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  exp_t m_e;

  adder_arbiter_if #(.WIDTH(W), .NREQ(NR)) bus ();

  adder_arbiter #(.WIDTH(W), .NREQ(NR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(int id, int a, int b, bit sub);
    exp_t e;
    int t, sa, sbv, r;
    t     = sub ? a + (15 - b) + 1 : a + b;
    e.id  = id;
    e.sum = W'(t);
    e.cf  = (t > 15);
    sa    = (a > 7) ? a - 16 : a;
    sbv   = (b > 7) ? b - 16 : b;
    r     = sub ? sa - sbv : sa + sbv;
    e.of  = (r > 7) || (r < -8);
    return e;
  endfunction

  task automatic set_op(int id, int a, int b, bit sub);
    bus.a[id*W +: W] = W'(a);
    bus.b[id*W +: W] = W'(b);
    bus.sub[id]      = sub;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    reset   = 1'b1;
    bus.req = '0;
    bus.en  = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    sb.delete();
  endtask

  // Response consumer: every rsp_valid pulse must match the queue head.
  always @(negedge clk) begin
    if (!reset && bus.rsp_valid !== '0) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected: rsp_valid=%b, none expected",
                 bus.rsp_valid);
      end else begin
        m_e = sb.pop_front();
        if (bus.rsp_valid !== 4'(1 << m_e.id) ||
            bus.rsp_sum !== m_e.sum ||
            bus.rsp_cf !== m_e.cf || bus.rsp_of !== m_e.of) begin
          n_fail++;
          $display("FAIL rsp: got vld=%b sum=%h cf=%b of=%b, want vld=%b sum=%h cf=%b of=%b",
                   bus.rsp_valid, bus.rsp_sum, bus.rsp_cf, bus.rsp_of,
                   4'(1 << m_e.id), m_e.sum, m_e.cf, m_e.of);
        end
      end
    end
  end

  task automatic test_reset;
    reset   = 1'b1;
    bus.en  = 1'b1;
    bus.req = '0;
    bus.sub = '0;
    bus.a   = '0;
    bus.b   = '0;
    tick;
    n_checks++;
    if (bus.gnt !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_gnt: got %b want 0000", bus.gnt);
    end
    n_checks++;
    if (bus.rsp_valid !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_rsp_valid: got %b want 0000", bus.rsp_valid);
    end
    n_checks++;
    if (bus.rsp_sum !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_sum: got %h want 0", bus.rsp_sum);
    end
    n_checks++;
    if (bus.rsp_cf !== 1'b0 || bus.rsp_of !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got cf=%b of=%b want 0 0",
               bus.rsp_cf, bus.rsp_of);
    end
    tick;
    reset = 1'b0;
  endtask

  task automatic test_basic;
    set_op(0, 3, 4, 0);
    bus.req = 4'b0001;
    tick;
    bus.req = '0;
    n_checks++;
    if (bus.gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL basic_gnt: got %b want 0001", bus.gnt);
    end
    sb.push_back(model(0, 3, 4, 0));
    tick;
    n_checks++;
    if (bus.rsp_valid !== 4'b0001 || bus.gnt !== 4'b0000) begin
      n_fail++;
      $display("FAIL basic_rsp: got vld=%b gnt=%b want 0001 0000",
               bus.rsp_valid, bus.gnt);
    end
    tick;
  endtask

  task automatic test_flags;
    int fa[3] = '{7, 8, 0};
    int fb[3] = '{1, 1, 1};
    bit fs[3] = '{0, 1, 1};
    logic [3:0] es[3] = '{4'h8, 4'h7, 4'hF};
    logic ec[3] = '{1'b0, 1'b1, 1'b0};
    logic eo[3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      set_op(0, fa[i], fb[i], fs[i]);
      bus.req = 4'b0001;
      tick;
      bus.req = '0;
      n_checks++;
      if (bus.gnt !== 4'b0001) begin
        n_fail++;
        $display("FAIL flags_gnt[%0d]: got %b want 0001", i, bus.gnt);
      end
      sb.push_back(model(0, fa[i], fb[i], fs[i]));
      tick;
      n_checks++;
      if (bus.rsp_sum !== es[i] || bus.rsp_cf !== ec[i] ||
          bus.rsp_of !== eo[i]) begin
        n_fail++;
        $display("FAIL flags[%0d]: got sum=%h cf=%b of=%b want %h %b %b",
                 i, bus.rsp_sum, bus.rsp_cf, bus.rsp_of,
                 es[i], ec[i], eo[i]);
      end
      tick;
    end
  endtask

  task automatic test_round_robin;
    apply_reset;
    for (int i = 0; i < NR; i++) set_op(i, i + 1, 2*i + 3, i[0]);
    bus.req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      tick;
      n_checks++;
      if (bus.gnt !== 4'(1 << (i % 4))) begin
        n_fail++;
        $display("FAIL rr_gnt[%0d]: got %b want %b",
                 i, bus.gnt, 4'(1 << (i % 4)));
      end
      sb.push_back(model(i % 4, (i % 4) + 1, 2*(i % 4) + 3, (i % 2) == 1));
      if (i > 0) begin
        n_checks++;
        if (bus.rsp_valid !== 4'(1 << ((i - 1) % 4))) begin
          n_fail++;
          $display("FAIL rr_rsp[%0d]: got %b want %b",
                   i, bus.rsp_valid, 4'(1 << ((i - 1) % 4)));
        end
      end
    end
    bus.req = '0;
    tick;
    n_checks++;
    if (bus.rsp_valid !== 4'b1000 || bus.gnt !== 4'b0000) begin
      n_fail++;
      $display("FAIL rr_tail: got vld=%b gnt=%b want 1000 0000",
               bus.rsp_valid, bus.gnt);
    end
    tick;
  endtask

  task automatic test_skip;
    apply_reset;
    set_op(2, 5, 6, 0);
    bus.req = 4'b0100;
    tick;
    n_checks++;
    if (bus.gnt !== 4'b0100) begin
      n_fail++;
      $display("FAIL skip_gnt2: got %b want 0100", bus.gnt);
    end
    sb.push_back(model(2, 5, 6, 0));
    set_op(3, 9, 9, 1);
    set_op(1, 1, 14, 0);
    bus.req = 4'b1010;
    tick;
    n_checks++;
    if (bus.gnt !== 4'b1000) begin
      n_fail++;
      $display("FAIL skip_gnt3: got %b want 1000", bus.gnt);
    end
    sb.push_back(model(3, 9, 9, 1));
    bus.req = 4'b0010;
    tick;
    n_checks++;
    if (bus.gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL skip_gnt1: got %b want 0010", bus.gnt);
    end
    sb.push_back(model(1, 1, 14, 0));
    bus.req = '0;
    tick;
    tick;
  endtask

  task automatic test_stall;
    apply_reset;
    set_op(1, 2, 2, 0);
    bus.req = 4'b0010;
    tick;
    n_checks++;
    if (bus.gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL stall_gnt: got %b want 0010", bus.gnt);
    end
    sb.push_back(model(1, 2, 2, 0));
    bus.en  = 1'b0;
    set_op(0, 6, 3, 1);
    bus.req = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_checks++;
      if (bus.gnt !== 4'b0000 || bus.rsp_valid !== 4'b0000) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got gnt=%b vld=%b want 0000 0000",
                 i, bus.gnt, bus.rsp_valid);
      end
    end
    bus.en = 1'b1;
    tick;
    bus.req = '0;
    n_checks++;
    if (bus.rsp_valid !== 4'b0010 || bus.rsp_sum !== 4'h4 ||
        bus.gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL stall_resume: got vld=%b sum=%h gnt=%b want 0010 4 0001",
               bus.rsp_valid, bus.rsp_sum, bus.gnt);
    end
    sb.push_back(model(0, 6, 3, 1));
    tick;
    n_checks++;
    if (bus.rsp_valid !== 4'b0001 || bus.gnt !== 4'b0000) begin
      n_fail++;
      $display("FAIL stall_next: got vld=%b gnt=%b want 0001 0000",
               bus.rsp_valid, bus.gnt);
    end
    tick;
    n_checks++;
    if (bus.rsp_valid !== 4'b0000) begin
      n_fail++;
      $display("FAIL stall_repeat: got vld=%b want 0000", bus.rsp_valid);
    end
  endtask

  task automatic test_reset_midstream;
    apply_reset;
    for (int i = 0; i < NR; i++) set_op(i, 15 - i, i, 0);
    bus.req = 4'b1111;
    tick;
    sb.push_back(model(0, 15, 0, 0));
    tick;
    sb.push_back(model(1, 14, 1, 0));
    reset   = 1'b1;
    bus.req = '0;
    #1;
    n_checks++;
    if (bus.gnt !== 4'b0000 || bus.rsp_valid !== 4'b0000 ||
        bus.rsp_sum !== 4'h0 || bus.rsp_cf !== 1'b0 ||
        bus.rsp_of !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got gnt=%b vld=%b sum=%h cf=%b of=%b want all 0",
               bus.gnt, bus.rsp_valid, bus.rsp_sum, bus.rsp_cf, bus.rsp_of);
    end
    sb.delete();
    tick;
    reset = 1'b0;
    tick;
    tick;
    n_checks++;
    if (bus.rsp_valid !== 4'b0000 || bus.gnt !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_flushed: got vld=%b gnt=%b want 0000 0000",
               bus.rsp_valid, bus.gnt);
    end
    bus.req = 4'b1111;
    tick;
    bus.req = '0;
    n_checks++;
    if (bus.gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL mid_first_gnt: got %b want 0001", bus.gnt);
    end
    sb.push_back(model(0, 15, 0, 0));
    tick;
    tick;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_flags;
    test_round_robin;
    test_skip;
    test_stall;
    test_reset_midstream;
    tick;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL rsp_missing: %0d responses outstanding, want 0",
               sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
